// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: FSM encoding, lane count and default base address.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } mem_state_e;

    localparam int unsigned DefaultWidth = 32;
    localparam int unsigned DefaultLanes = DefaultWidth / 8;

    // Also the IFU reset PC, so both agree on where memory starts.
    localparam logic [31:0] DefaultBaseAddr = 32'h8000_0000;

    localparam int unsigned CntWidth = 4;

    function automatic int unsigned num_lanes(input int unsigned width);
        return width / 8;
    endfunction

endpackage

// File: rtl/mem_sp_array.sv
// Single-port word array: combinational read, synchronous byte-enable write, contents never reset.
module mem_sp_array #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [WIDTH/8-1:0]    wmask_i,
    input  logic [DEPTH_LOG2-1:0] addr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    output logic [WIDTH-1:0]      rdata_o
);

    localparam int unsigned Words = 2 ** DEPTH_LOG2;
    localparam int unsigned Lanes = WIDTH / 8;

    logic [WIDTH-1:0] mem_q [Words];

    assign rdata_o = mem_q[addr_i];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < Lanes; i++) begin
                if (wmask_i[i]) begin
                    mem_q[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory slave: latches a request, waits LATENCY edges, then reads or
// byte-writes the word array and holds the response until the requester takes it.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned      WIDTH      = DefaultWidth,
    parameter int unsigned      DEPTH_LOG2 = 10,
    parameter logic [WIDTH-1:0] BASE_ADDR  = WIDTH'(DefaultBaseAddr),
    parameter int unsigned      LATENCY    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [WIDTH-1:0]   req_addr,
    input  logic               req_wen,
    input  logic [WIDTH/8-1:0] req_wmask,
    input  logic [WIDTH-1:0]   req_wdata,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [WIDTH-1:0]   resp_rdata,
    output logic               resp_err
);

    localparam int unsigned Lanes = num_lanes(WIDTH);
    localparam logic [CntWidth-1:0] LatencyCnt = CntWidth'(LATENCY);

    mem_state_e          state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]    addr_q, addr_d;
    logic                wen_q, wen_d;
    logic [Lanes-1:0]    wmask_q, wmask_d;
    logic [WIDTH-1:0]    wdata_q, wdata_d;
    logic                resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0]    rdata_q, rdata_d;
    logic                err_q, err_d;

    logic [WIDTH-1:0]      offset;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic                  fault;
    logic                  commit;
    logic                  arr_we;
    logic [WIDTH-1:0]      arr_rdata;
    logic                  unused_offset;

    // Unsigned compare against BASE_ADDR first, so a wrapped offset can never alias into range.
    assign offset        = addr_q - BASE_ADDR;
    assign word_idx      = offset[DEPTH_LOG2+1:2];
    assign fault         = (addr_q[1:0] != 2'b00) || (addr_q < BASE_ADDR) ||
                           (offset[WIDTH-1:DEPTH_LOG2+2] != '0);
    assign unused_offset = ^offset[1:0];

    assign commit = (state_q == StWait) && (cnt_q == CntWidth'(1));
    assign arr_we = commit && wen_q && !fault;

    mem_sp_array #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk_i   (clk),
        .we_i    (arr_we),
        .wmask_i (wmask_q),
        .addr_i  (word_idx),
        .wdata_i (wdata_q),
        .rdata_o (arr_rdata)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wen_d        = wen_q;
        wmask_d      = wmask_q;
        wdata_d      = wdata_q;
        resp_valid_d = resp_valid_q;
        rdata_d      = rdata_q;
        err_d        = err_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wen_d   = req_wen;
                    wmask_d = req_wmask;
                    wdata_d = req_wdata;
                    // Counting the full latency here puts resp_valid LATENCY edges after accept.
                    cnt_d   = LatencyCnt;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (commit) begin
                    cnt_d        = '0;
                    state_d      = StResp;
                    resp_valid_d = 1'b1;
                    err_d        = fault;
                    rdata_d      = (!wen_q && !fault) ? arr_rdata : '0;
                end else begin
                    cnt_d = cnt_q - CntWidth'(1);
                end
            end
            StResp: begin
                if (resp_ready) begin
                    state_d      = StIdle;
                    resp_valid_d = 1'b0;
                    rdata_d      = '0;
                    err_d        = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            addr_q       <= '0;
            wen_q        <= 1'b0;
            wmask_q      <= '0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wen_q        <= wen_d;
            wmask_q      <= wmask_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (LATENCY 2, 4, 1) checked against a word-array model.
module tb_mem_responder;

    localparam logic [31:0] Base  = 32'h8000_0000;
    localparam int          Words = 1024;

    logic        clk;
    logic        rst;
    logic        req_valid  [3];
    logic        req_ready  [3];
    logic [31:0] req_addr   [3];
    logic        req_wen    [3];
    logic [3:0]  req_wmask  [3];
    logic [31:0] req_wdata  [3];
    logic        resp_valid [3];
    logic        resp_ready [3];
    logic [31:0] resp_rdata [3];
    logic        resp_err   [3];

    logic [31:0] mdl [3][Words];
    int          cyc;
    int          n_tests;
    int          n_fail;

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        mem_responder #(
            .WIDTH      (32),
            .DEPTH_LOG2 (10),
            .BASE_ADDR  (32'h8000_0000),
            .LATENCY    ((g == 0) ? 2 : ((g == 1) ? 4 : 1))
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_addr   (req_addr[g]),
            .req_wen    (req_wen[g]),
            .req_wmask  (req_wmask[g]),
            .req_wdata  (req_wdata[g]),
            .resp_valid (resp_valid[g]),
            .resp_ready (resp_ready[g]),
            .resp_rdata (resp_rdata[g]),
            .resp_err   (resp_err[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 4 : 1);
    endfunction

    // Reference: byte-addressed window [Base, Base + 4*Words), word aligned.
    task automatic model_txn(input int d, input logic [31:0] a, input logic w,
                             input logic [3:0] m, input logic [31:0] wd,
                             output logic [31:0] erd, output logic eer);
        int idx;
        erd = '0;
        eer = (a % 4 != 0) || (a < Base) || (a >= Base + 4 * Words);
        if (!eer) begin
            idx = int'((a - Base) / 4);
            if (w) begin
                for (int i = 0; i < 4; i++) begin
                    if (m[i]) mdl[d][idx][i*8 +: 8] = wd[i*8 +: 8];
                end
            end else begin
                erd = mdl[d][idx];
            end
        end
    endtask

    task automatic do_txn(input int d, input logic [31:0] a, input logic w, input logic [3:0] m,
                          input logic [31:0] wd, input int hold,
                          output logic [31:0] rd, output logic er, output int lat,
                          output int acc, output bit stable, output bit idle_ok);
        int n;
        req_valid[d]  = 1'b1;
        req_addr[d]   = a;
        req_wen[d]    = w;
        req_wmask[d]  = m;
        req_wdata[d]  = wd;
        resp_ready[d] = (hold == 0);
        n = 0;
        while (!req_ready[d] && n < 50) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        acc = cyc;
        req_valid[d] = 1'b0;
        req_addr[d]  = $urandom;
        req_wen[d]   = 1'($urandom);
        req_wmask[d] = 4'($urandom);
        req_wdata[d] = $urandom;
        lat = 0;
        while (!resp_valid[d] && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        if (resp_valid[d] !== 1'b1) lat = -1;
        rd = resp_rdata[d];
        er = resp_err[d];
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (resp_valid[d] !== 1'b1 || resp_rdata[d] !== rd || resp_err[d] !== er ||
                req_ready[d] !== 1'b0) stable = 1'b0;
        end
        resp_ready[d] = 1'b1;
        @(posedge clk); #1;
        idle_ok = (resp_valid[d] === 1'b0) && (req_ready[d] === 1'b1) &&
                  (resp_rdata[d] === 32'h0) && (resp_err[d] === 1'b0);
        resp_ready[d] = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] rd, erd;
        logic er, eer;
        int lat, acc, n;
        bit st, ok;
        rst = 1'b0;
        @(posedge clk); @(posedge clk); #5;
        rst = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (req_ready[0] !== 1'b1 || resp_valid[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: req_ready=%b resp_valid=%b want 1/0", req_ready[0],
                     resp_valid[0]);
        end
        model_txn(0, Base, 1'b1, 4'hF, 32'h0000_0413, erd, eer);
        do_txn(0, Base, 1'b1, 4'hF, 32'h0000_0413, 0, rd, er, lat, acc, st, ok);
        // Leave a read response pending, then reset it away mid-cycle.
        req_valid[0] = 1'b1; req_addr[0] = Base; req_wen[0] = 1'b0; resp_ready[0] = 1'b0;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        n = 0;
        while (!resp_valid[0] && n < 20) begin
            @(posedge clk); #1; n++;
        end
        n_tests++;
        if (resp_valid[0] !== 1'b1 || resp_rdata[0] !== 32'h0000_0413) begin
            n_fail++;
            $display("FAIL pre_reset_resp: valid=%b rdata=%h want 1/00000413", resp_valid[0],
                     resp_rdata[0]);
        end
        #4 rst = 1'b0;
        #1;
        n_tests++;
        if (resp_valid[0] !== 1'b0 || resp_rdata[0] !== 32'h0 || resp_err[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b rdata=%h err=%b want 0/0/0", resp_valid[0],
                     resp_rdata[0], resp_err[0]);
        end
        @(posedge clk); #4;
        rst = 1'b1;
        @(posedge clk); #1;
        do_txn(0, Base, 1'b0, 4'h0, 32'h0, 0, rd, er, lat, acc, st, ok);
        n_tests++;
        if (lat != 2 || rd !== 32'h0000_0413 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL read_after_reset: lat=%0d rdata=%h err=%b want 2/00000413/0", lat, rd,
                     er);
        end
    endtask

    task automatic test_masked_write;
        logic [31:0] rd, erd;
        logic er, eer;
        int lat, acc;
        bit st, ok;
        model_txn(0, Base + 32'h10, 1'b1, 4'hF, 32'h1122_3344, erd, eer);
        do_txn(0, Base + 32'h10, 1'b1, 4'hF, 32'h1122_3344, 0, rd, er, lat, acc, st, ok);
        model_txn(0, Base + 32'h10, 1'b1, 4'b0101, 32'hAABB_CCDD, erd, eer);
        do_txn(0, Base + 32'h10, 1'b1, 4'b0101, 32'hAABB_CCDD, 0, rd, er, lat, acc, st, ok);
        n_tests++;
        if (rd !== 32'h0 || er !== 1'b0 || lat != 2 || !ok) begin
            n_fail++;
            $display("FAIL write_resp: rdata=%h err=%b lat=%0d idle=%b want 0/0/2/1", rd, er,
                     lat, ok);
        end
        model_txn(0, Base + 32'h10, 1'b0, 4'h0, 32'h0, erd, eer);
        do_txn(0, Base + 32'h10, 1'b0, 4'h0, 32'h0, 0, rd, er, lat, acc, st, ok);
        n_tests++;
        if (rd !== 32'h11BB_33DD || rd !== erd || er !== 1'b0) begin
            n_fail++;
            $display("FAIL masked_read: rdata=%h err=%b want 11bb33dd/0", rd, er);
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] rd, erd;
        logic er, eer;
        int lat, acc;
        bit st, ok;
        model_txn(0, Base + 32'h10, 1'b0, 4'h0, 32'h0, erd, eer);
        do_txn(0, Base + 32'h10, 1'b0, 4'h0, 32'h0, 5, rd, er, lat, acc, st, ok);
        n_tests++;
        if (!st) begin
            n_fail++;
            $display("FAIL backpressure_hold: stable=%b want 1", st);
        end
        n_tests++;
        if (!ok || rd !== erd || er !== 1'b0 || lat != 2) begin
            n_fail++;
            $display("FAIL backpressure_release: idle=%b rdata=%h err=%b lat=%0d want 1/%h/0/2",
                     ok, rd, er, lat, erd);
        end
    endtask

    task automatic test_faults;
        logic [31:0] rd, erd;
        logic er, eer;
        int lat, acc;
        bit st, ok;
        model_txn(0, Base + 32'hFFC, 1'b1, 4'hF, 32'h5A5A_0FFC, erd, eer);
        do_txn(0, Base + 32'hFFC, 1'b1, 4'hF, 32'h5A5A_0FFC, 0, rd, er, lat, acc, st, ok);
        do_txn(0, Base + 32'h2, 1'b0, 4'h0, 32'h0, 0, rd, er, lat, acc, st, ok);
        n_tests++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL fault_misaligned: err=%b rdata=%h want 1/0", er, rd);
        end
        do_txn(0, 32'h7FFF_FFFC, 1'b1, 4'hF, 32'hFFFF_FFFF, 0, rd, er, lat, acc, st, ok);
        n_tests++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL fault_below_base: err=%b rdata=%h want 1/0", er, rd);
        end
        do_txn(0, Base + 32'h1000, 1'b0, 4'h0, 32'h0, 0, rd, er, lat, acc, st, ok);
        n_tests++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL fault_above_top: err=%b rdata=%h want 1/0", er, rd);
        end
        model_txn(0, Base + 32'hFFC, 1'b0, 4'h0, 32'h0, erd, eer);
        do_txn(0, Base + 32'hFFC, 1'b0, 4'h0, 32'h0, 0, rd, er, lat, acc, st, ok);
        n_tests++;
        if (er !== eer || rd !== erd) begin
            n_fail++;
            $display("FAIL last_word_unchanged: err=%b rdata=%h want %b/%h", er, rd, eer, erd);
        end
    endtask

    task automatic test_wait_reset;
        logic [31:0] rd, erd;
        logic er, eer;
        int lat, acc, seen;
        bit st, ok;
        model_txn(1, Base + 32'h20, 1'b1, 4'hF, 32'h0BAD_F00D, erd, eer);
        do_txn(1, Base + 32'h20, 1'b1, 4'hF, 32'h0BAD_F00D, 0, rd, er, lat, acc, st, ok);
        n_tests++;
        if (lat != 4 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL latency4: lat=%0d err=%b want 4/0", lat, er);
        end
        req_valid[1] = 1'b1; req_addr[1] = Base + 32'h20; req_wen[1] = 1'b1;
        req_wmask[1] = 4'hF; req_wdata[1] = 32'hDEAD_BEEF; resp_ready[1] = 1'b1;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #3 rst = 1'b0;
        @(posedge clk); @(posedge clk); #4;
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (resp_valid[1] !== 1'b0) seen++;
        end
        resp_ready[1] = 1'b0;
        n_tests++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL wait_reset_no_resp: valid cycles=%0d want 0", seen);
        end
        model_txn(1, Base + 32'h20, 1'b0, 4'h0, 32'h0, erd, eer);
        do_txn(1, Base + 32'h20, 1'b0, 4'h0, 32'h0, 0, rd, er, lat, acc, st, ok);
        n_tests++;
        if (rd !== erd || rd !== 32'h0BAD_F00D || er !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_reset_discard: rdata=%h err=%b want 0badf00d/0", rd, er);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd, erd;
        logic er, eer;
        int lat, acc, prev;
        bit st, ok;
        for (int i = 0; i < 3; i++) begin
            model_txn(2, Base + 32'(4 * i), 1'b1, 4'hF, 32'hC0DE_0000 + 32'(i), erd, eer);
            do_txn(2, Base + 32'(4 * i), 1'b1, 4'hF, 32'hC0DE_0000 + 32'(i), 0, rd, er, lat, acc,
                   st, ok);
        end
        prev = 0;
        for (int i = 0; i < 3; i++) begin
            model_txn(2, Base + 32'(4 * i), 1'b0, 4'h0, 32'h0, erd, eer);
            do_txn(2, Base + 32'(4 * i), 1'b0, 4'h0, 32'h0, 0, rd, er, lat, acc, st, ok);
            n_tests++;
            if (lat != 1 || rd !== erd || er !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_read%0d: lat=%0d rdata=%h err=%b want 1/%h/0", i, lat, rd, er,
                         erd);
            end
            if (i > 0) begin
                n_tests++;
                if (acc - prev != 3) begin
                    n_fail++;
                    $display("FAIL b2b_spacing%0d: got %0d cycles want 3", i, acc - prev);
                end
            end
            prev = acc;
        end
    endtask

    task automatic test_random;
        logic [31:0] rd, erd, a, wd;
        logic er, eer, w;
        logic [3:0] m;
        logic [31:0] bad [4];
        int lat, acc;
        bit st, ok;
        bad[0] = Base + 32'h2; bad[1] = Base - 32'h4;
        bad[2] = Base + 32'h1000; bad[3] = Base + 32'h1001;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) begin
                wd = $urandom;
                model_txn(d, Base + 32'(4 * i), 1'b1, 4'hF, wd, erd, eer);
                do_txn(d, Base + 32'(4 * i), 1'b1, 4'hF, wd, 0, rd, er, lat, acc, st, ok);
            end
            for (int i = 0; i < 30; i++) begin
                if ($urandom_range(0, 7) == 0) a = bad[$urandom_range(0, 3)];
                else a = Base + 32'(4 * $urandom_range(0, 15));
                w  = 1'($urandom);
                m  = 4'($urandom);
                wd = $urandom;
                model_txn(d, a, w, m, wd, erd, eer);
                do_txn(d, a, w, m, wd, $urandom_range(0, 2), rd, er, lat, acc, st, ok);
                n_tests++;
                if (rd !== erd || er !== eer || lat != lat_of(d) || !st || !ok) begin
                    n_fail++;
                    $display("FAIL rand_d%0d_%0d: a=%h w=%b rdata=%h err=%b lat=%0d st=%b idle=%b want %h/%b/%0d",
                             d, i, a, w, rd, er, lat, st, ok, erd, eer, lat_of(d));
                end
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int d = 0; d < 3; d++) begin
            req_valid[d]  = 1'b0;
            req_addr[d]   = '0;
            req_wen[d]    = 1'b0;
            req_wmask[d]  = '0;
            req_wdata[d]  = '0;
            resp_ready[d] = 1'b0;
        end
        test_reset();
        test_masked_write();
        test_backpressure();
        test_faults();
        test_wait_reset();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
